// File: rtl/pkt_arb_requester.sv
// Packet requester: queues descriptors, arbitrates for a shared bus and streams len+1 beats per packet.
// Optional statistics counters are enabled by defining PKT_ARB_REQUESTER_STATS_EN.
module pkt_arb_requester #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [LEN_W-1:0]  s_len,
    input  logic [DATA_W-1:0] s_base,
    output logic              req,
    input  logic              grant,
    output logic              fin,
    input  logic              ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef PKT_ARB_REQUESTER_STATS_EN
    ,
    output logic [15:0]       pkt_count,
    output logic [15:0]       stall_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [LEN_W-1:0]  len_mem  [DEPTH];
    logic [DATA_W-1:0] base_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [LEN_W-1:0] beat_reg;
    logic [LEN_W-1:0] beat_next;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [LEN_W-1:0]  head_len;
    logic [DATA_W-1:0] head_base;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    // Gating with reset keeps s_ready low for the whole reset window.
    assign s_ready   = reset && !full;
    assign push      = s_valid && s_ready;
    assign pop       = (state_reg == ST_FIN);
    assign head_len  = len_mem[rd_ptr_reg];
    assign head_base = base_mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push) begin
            len_mem[wr_ptr_reg]  <= s_len;
            base_mem[wr_ptr_reg] <= s_base;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            beat_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        req        = 1'b0;
        fin        = 1'b0;
        m_valid    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (grant) begin
                    state_next = ST_XFER;
                    beat_next  = '0;
                end
            end
            ST_XFER: begin
                // A withdrawn grant simply pauses the packet; the beat index is held.
                req     = 1'b1;
                m_valid = grant;
                if (grant && ready) begin
                    if (beat_reg == head_len) begin
                        state_next = ST_FIN;
                    end else begin
                        beat_next = beat_reg + LEN_W'(1);
                    end
                end
            end
            default: begin
                fin        = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign m_data = m_valid ? (head_base + DATA_W'(beat_reg)) : '0;
    assign m_last = m_valid && (beat_reg == head_len);

`ifdef PKT_ARB_REQUESTER_STATS_EN
    logic [15:0] pkt_count_reg;
    logic [15:0] stall_count_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pkt_count_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            if (state_reg == ST_FIN) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
            if ((state_reg == ST_XFER) && m_valid && !ready) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
        end
    end

    assign pkt_count   = pkt_count_reg;
    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_pkt_arb_requester.sv
// Bench for pkt_arb_requester: descriptor-queue reference model compared every cycle, plus directed literal checks.
module tb_pkt_arb_requester;
    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 4;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          s_valid = 1'b0;
    logic [LW-1:0] s_len   = '0;
    logic [DW-1:0] s_base  = '0;
    logic          grant   = 1'b0;
    logic          ready   = 1'b1;
    logic          s_ready;
    logic          req;
    logic          fin;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef PKT_ARB_REQUESTER_STATS_EN
    logic [15:0]   pkt_count;
    logic [15:0]   stall_count;
`endif

    pkt_arb_requester #(.DATA_W(DW), .LEN_W(LW), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_len   (s_len),
        .s_base  (s_base),
        .req     (req),
        .grant   (grant),
        .fin     (fin),
        .ready   (ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last)
`ifdef PKT_ARB_REQUESTER_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: descriptor queue plus packet phase (0 idle, 1 requesting, 2 streaming, 3 finishing).
    int unsigned q_len[$];
    int unsigned q_base[$];
    int          ph = 0;
    int unsigned beat = 0;
    int unsigned mpkt = 0;
    int unsigned mstall = 0;

    always @(posedge clock) begin : model
        bit do_push;
        bit do_pop;
        if (!reset) begin
            q_len.delete();
            q_base.delete();
            ph = 0; beat = 0; mpkt = 0; mstall = 0;
        end else begin
            do_push = s_valid && (q_len.size() < DEPTH);
            do_pop  = (ph == 3);
            case (ph)
                0: if (q_len.size() > 0) ph = 1;
                1: if (grant) begin ph = 2; beat = 0; end
                2: begin
                    if (grant && !ready) mstall = (mstall + 1) & 32'hFFFF;
                    if (grant && ready) begin
                        if (beat == q_len[0]) ph = 3;
                        else beat = beat + 1;
                    end
                end
                default: begin ph = 0; mpkt = (mpkt + 1) & 32'hFFFF; end
            endcase
            if (do_pop) begin
                void'(q_len.pop_front());
                void'(q_base.pop_front());
            end
            if (do_push) begin
                q_len.push_back(int'(s_len));
                q_base.push_back(s_base);
            end
        end
    end

    always @(negedge clock) begin : compare
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
        if (checking) begin
            e_valid = (ph == 2) && grant;
            e_data  = e_valid ? DW'(q_base[0] + beat) : '0;
            e_last  = e_valid && (beat == q_len[0]);
            check("cmp_s_ready", s_ready, reset && (q_len.size() < DEPTH));
            check("cmp_req", req, (ph == 1) || (ph == 2));
            check("cmp_fin", fin, ph == 3);
            check("cmp_m_valid", m_valid, e_valid);
            check("cmp_m_data", m_data, e_data);
            check("cmp_m_last", m_last, e_last);
`ifdef PKT_ARB_REQUESTER_STATS_EN
            check("cmp_pkt_count", pkt_count, mpkt[15:0]);
            check("cmp_stall_count", stall_count, mstall[15:0]);
`endif
        end
    end

    // Observation of the bus for the directed literal checks.
    logic [DW-1:0] cap_data[$];
    logic          cap_last[$];
    int fin_cnt = 0;
    int wait_cnt = 0;
    int stall_cnt = 0;

    always @(negedge clock) begin
        if (checking) begin
            if (m_valid && ready) begin
                cap_data.push_back(m_data);
                cap_last.push_back(m_last);
            end
            if (fin) begin
                fin_cnt++;
                $display("[%0t] packet complete, %0d beats seen so far", $time, cap_data.size());
            end
            if (req && !grant) wait_cnt++;
            if (m_valid && !ready) stall_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
        fin_cnt = 0; wait_cnt = 0; stall_cnt = 0;
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout, required event within bound", name);
    endtask

    task automatic push(input int unsigned len, input int unsigned base);
        s_valid = 1'b1;
        s_len   = LW'(len);
        s_base  = DW'(base);
        for (int i = 0; i < 200; i++) begin
            if (s_ready) begin
                tick();
                s_valid = 1'b0;
                $display("[%0t] descriptor pushed len=%0d base=%0h", $time, len, base);
                return;
            end
            tick();
        end
        s_valid = 1'b0;
        timeout("push");
    endtask

    task automatic wait_fins(input int n);
        for (int i = 0; i < 400; i++) begin
            if (fin_cnt >= n) return;
            tick();
        end
        timeout("wait_fin");
    endtask

    task automatic wait_beat(input logic [DW-1:0] d);
        for (int i = 0; i < 200; i++) begin
            if (m_valid && m_data == d) return;
            tick();
        end
        timeout("wait_beat");
    endtask

    task automatic check_seq(input string name, input logic [DW-1:0] base, input int n);
        check({name, "_count"}, cap_data.size(), n);
        for (int i = 0; i < n && i < cap_data.size(); i++) begin
            check({name, "_data"}, cap_data[i], base + DW'(i));
            check({name, "_last"}, cap_last[i], i == n - 1);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [DW-1:0] exp1[4];
        bit noisy;
        exp1 = '{32'h100, 32'h101, 32'h102, 32'h103};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checking = 1'b1;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_req", req, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        reset = 1'b1;
        #1;
        check("rel_s_ready", s_ready, 1'b1);
        tick();

        // len=3 with grant and ready tied high
        grant = 1'b1; ready = 1'b1;
        clear_cap();
        push(3, 32'h100);
        check("t1_req_idle", req, 1'b0);
        tick();
        check("t1_req_rise", req, 1'b1);
        wait_fins(1);
        tick();
        check("t1_count", cap_data.size(), 4);
        for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
            check("t1_data", cap_data[i], exp1[i]);
            check("t1_last", cap_last[i], i == 3);
        end

        // len=0, grant four cycles late
        grant = 1'b0;
        clear_cap();
        push(0, 32'hAA);
        for (int i = 0; i < 20 && !req; i++) tick();
        repeat (4) tick();
        grant = 1'b1;
        wait_fins(1);
        tick();
        check("t2_wait", wait_cnt, 4);
        check_seq("t2", 32'hAA, 1);

        // len=4 with ready low on first presentation of beats 1 and 3
        begin
            bit st1 = 1'b0;
            bit st3 = 1'b0;
            clear_cap();
            push(4, 32'h200);
            for (int i = 0; i < 100 && fin_cnt < 1; i++) begin
                if (m_valid && m_data == 32'h201 && !st1) begin ready = 1'b0; st1 = 1'b1; end
                else if (m_valid && m_data == 32'h203 && !st3) begin ready = 1'b0; st3 = 1'b1; end
                else ready = 1'b1;
                tick();
            end
            ready = 1'b1;
            tick();
            check("t3_stalls", stall_cnt, 2);
            check_seq("t3", 32'h200, 5);
`ifdef PKT_ARB_REQUESTER_STATS_EN
            check("t3_stall_count", stall_count, 16'd2);
            check("t3_pkt_count", pkt_count, 16'd3);
`endif
        end

        // Fill the FIFO without grant, fifth descriptor must wait for the first FIN
        grant = 1'b0;
        clear_cap();
        push(1, 32'h300);
        push(1, 32'h310);
        push(1, 32'h320);
        push(1, 32'h330);
        check("t4_full", s_ready, 1'b0);
        s_valid = 1'b1; s_len = 8'd1; s_base = 32'h340;
        tick(); tick();
        check("t4_held", s_ready, 1'b0);
        check("t4_no_fin", fin_cnt, 0);
        grant = 1'b1;
        push(1, 32'h340);
        check("t4_accept_after_fin", fin_cnt, 1);
        wait_fins(5);
        tick();
        check("t4_count", cap_data.size(), 10);
        for (int i = 0; i < 10 && i < cap_data.size(); i++) begin
            check("t4_data", cap_data[i], 32'h300 + DW'((i / 2) * 16 + (i % 2)));
            check("t4_last", cap_last[i], (i % 2) == 1);
        end

        // Grant withdrawn for three cycles after beat 2
        clear_cap();
        push(5, 32'h400);
        wait_beat(32'h402);
        tick();
        grant = 1'b0;
        #1;
        check("t5_paused_valid", m_valid, 1'b0);
        check("t5_paused_req", req, 1'b1);
        repeat (3) tick();
        grant = 1'b1;
        #1;
        check("t5_resume", m_data, 32'h403);
        wait_fins(1);
        tick();
        check("t5_gap", wait_cnt, 3);
        check_seq("t5", 32'h400, 6);

        // Reset in the middle of a packet with two descriptors queued
        clear_cap();
        push(7, 32'h500);
        push(0, 32'h600);
        push(0, 32'h610);
        wait_beat(32'h502);
        reset = 1'b0;
        tick();
        check("t6_req", req, 1'b0);
        check("t6_fin", fin, 1'b0);
        check("t6_m_valid", m_valid, 1'b0);
        check("t6_m_data", m_data, 32'h0);
        check("t6_m_last", m_last, 1'b0);
        check("t6_s_ready", s_ready, 1'b0);
`ifdef PKT_ARB_REQUESTER_STATS_EN
        check("t6_pkt_count", pkt_count, 16'd0);
`endif
        reset = 1'b1;
        #1;
        check("t6_rel_s_ready", s_ready, 1'b1);
        clear_cap();
        noisy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req || fin) noisy = 1'b1;
            tick();
        end
        check("t6_quiet", noisy, 1'b0);
        check("t6_no_fin", fin_cnt, 0);
        push(0, 32'h700);
        wait_fins(1);
        tick();
        check_seq("t6", 32'h700, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
